// File: rtl/stream_defs.sv
// stream_defs: shared definitions for sram_stream_reader and its output FIFO.
// Holds the FSM state encodings, the loop extent width and the FIFO tag layout.
package stream_defs;

  // Width of the inner/outer trip-count inputs.
  localparam int EXT_W = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // FIFO entries are tagged as {last, data}: bit [w] is the last flag and
  // bits [w-1:0] carry the SRAM word.
  function automatic int tag_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with an occupancy count.
// Output data is read straight from the storage registers and forced to zero
// when empty. Push and pop in the same cycle are allowed, also when full.
// rst flushes the FIFO synchronously.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  // Pointer and occupancy bookkeeping, flushed by rst.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order the always blocks evaluate.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the storage array is deliberately not reset; an entry is only
  // visible once count covers it, and dout is gated to zero when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_stream_reader.sv
// sram_stream_reader: walks a 2-level affine address pattern over a
// single_port_sram, issues one-word reads and re-emits the words as a
// valid/ready stream with last-element marking. Reads are only issued when a
// FIFO slot is reserved for the returning word, so backpressure never drops
// SRAM data.
// Optional: define SRAM_STREAM_READER_PERF_EN to add the stall_cycles and
// credit_stalls performance counters.
module sram_stream_reader
  import stream_defs::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    stride0,
  input  logic [AW-1:0]    stride1,
  input  logic [EXT_W-1:0] extent0,
  input  logic [EXT_W-1:0] extent1,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    sram_addr,
  output logic             sram_ren,
  output logic             sram_wen,
  input  logic [WIDTH-1:0] sram_q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
`ifdef SRAM_STREAM_READER_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      credit_stalls
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = tag_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    stride0_r;
  logic [AW-1:0]    stride1_r;
  logic [AW-1:0]    addr_r;
  logic [AW-1:0]    row_r;
  logic [EXT_W-1:0] ext0_r;
  logic [EXT_W-1:0] ext1_r;
  logic [EXT_W-1:0] i0;
  logic [EXT_W-1:0] i1;
  logic             inflight;
  logic             inflight_last;
  logic             busy_r;
  logic             done_r;

  logic             accept;
  logic             row_end;
  logic             is_last;
  logic             credit_ok;
  logic             issue;
  logic             fifo_pop;
  logic             fifo_valid;
  logic [CW-1:0]    fifo_count;
  logic [TW-1:0]    fifo_dout;
  logic [31:0]      occupancy;

  assign accept  = (state == ST_IDLE) && start;
  assign row_end = (i0 == ext0_r - EXT_W'(1));
  assign is_last = row_end && (i1 == ext1_r - EXT_W'(1));

  // Entries that will sit in the FIFO next cycle: stored words plus the word
  // returning from the SRAM this cycle, net of a word leaving downstream.
  // A new read is only issued if that leaves room for its own word.
  assign fifo_pop  = fifo_valid && out_ready;
  assign occupancy = 32'(fifo_count) + 32'(inflight) - 32'(fifo_pop);
  assign credit_ok = (occupancy < 32'(FIFO_DEPTH));

  assign busy      = busy_r;
  assign done      = done_r;
  assign sram_addr = addr_r;
  assign sram_ren  = issue;
  assign sram_wen  = 1'b0;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_dout[WIDTH-1:0];
  assign out_last  = fifo_dout[WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state and read-issue decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ((extent0 == '0) || (extent1 == '0)) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = credit_ok;
        if (credit_ok && is_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!inflight && (fifo_count == '0)) state_next = ST_FINISH;
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Config latch, index/address stepping and SRAM return tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride0_r     <= '0;
      stride1_r     <= '0;
      addr_r        <= '0;
      row_r         <= '0;
      ext0_r        <= '0;
      ext1_r        <= '0;
      i0            <= '0;
      i1            <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && is_last;
      done_r        <= (state == ST_FINISH);
      if (state == ST_FINISH) busy_r <= 1'b0;

      if (accept) begin
        stride0_r <= stride0;
        stride1_r <= stride1;
        ext0_r    <= extent0;
        ext1_r    <= extent1;
        i0        <= '0;
        i1        <= '0;
        addr_r    <= base;
        row_r     <= base;
        busy_r    <= 1'b1;
      end else if (issue) begin
        if (!row_end) begin
          i0     <= i0 + EXT_W'(1);
          addr_r <= addr_r + stride0_r;
        end else begin
          i0     <= '0;
          i1     <= i1 + EXT_W'(1);
          row_r  <= row_r + stride1_r;
          addr_r <= row_r + stride1_r;
        end
      end
    end
  end

  // Output buffer: the SRAM word is written the cycle after its read,
  // unconditionally, because the read was only issued with a slot reserved.
  sync_fifo #(
    .WIDTH (TW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, sram_q}),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

`ifdef SRAM_STREAM_READER_PERF_EN
  // Saturating counters for downstream stalls and credit-limited issue cycles.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cycles  <= '0;
      credit_stalls <= '0;
    end else begin
      if (fifo_valid && !out_ready && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if ((state == ST_ISSUE) && !credit_ok && (credit_stalls != '1)) begin
        credit_stalls <= credit_stalls + 32'd1;
      end
    end
  end
`endif

endmodule
